flash_access_arbiter: RTL and testbench
=======================================

FLASH_ACCESS_ARBITER -- requirements
Module: flash_access_arbiter

Interface
REQ-001 Parameter WR_CYCLES, default 16: WAIT-state length for a word write; at least the NOR interface write-sequence duration.
REQ-002 Parameter RD_CYCLES, default 24: WAIT-state length for a word read; at least the NOR interface read-sequence duration.
REQ-003 Parameter SETTLE_CYCLES, default 32: post-reset lockout length.
REQ-004 CLK  in  1  sole clock; all logic on rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 wr_req  in  1  writer request; level, held until wr_ack.
REQ-007 wr_addr  in  22  writer word address.
REQ-008 wr_data  in  16  writer data word.
REQ-009 wr_ack  out  1  one-cycle pulse: write sequence complete.
REQ-010 rd_req  in  1  reader request; level, held until rd_ack.
REQ-011 rd_addr  in  22  reader word address.
REQ-012 rd_ack  out  1  one-cycle pulse: read complete, rd_data valid.
REQ-013 rd_data  out  16  captured read word; holds until next read completes.
REQ-014 CMD_OUT  out  2  to NOR interface command input: 0 NOP, 1 read, 2 write.
REQ-015 A_out  out  22  to NOR interface address input.
REQ-016 D_out  out  16  to NOR interface write-data input.
REQ-017 D_read  in  16  from NOR interface read-data output.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 FSM states: INIT, IDLE, ISSUE, WAIT, DONE.
- INIT: counts SETTLE_CYCLES, then goes to IDLE.
- IDLE: samples wr_req and rd_req; if either is high, latches the grant, A_out, and D_out (on write), then goes to ISSUE.
- ISSUE: one cycle.
- WAIT: WR_CYCLES or RD_CYCLES cycles.
- DONE: one cycle, then IDLE.
REQ-020 CMD_OUT shall be 2 (write) or 1 (read) only during the single ISSUE cycle and 0 in every other cycle.
REQ-021 A_out and D_out shall remain stable from ISSUE through DONE, regardless of requester input changes.
REQ-022 Grant arbitration is two-way round-robin.
- A last_grant bit selects the loser of the previous grant when both requests are high in IDLE.
- A single request is granted immediately.
REQ-023 The WAIT counter is 6 bits wide, loads the granted length minus 1, decrements to 0, and leaves WAIT on 0.
REQ-024 On a read, rd_data shall register D_read on the last WAIT cycle.
REQ-025 rd_ack (read) or wr_ack (write) shall pulse in DONE.
REQ-026 Latency from a request sampled in IDLE at cycle t:
- ISSUE at t+1.
- Write: ack at t+2+WR_CYCLES.
- Read: ack at t+2+RD_CYCLES.
REQ-027 Requesters shall deassert req on the cycle after ack; a req still high in the following IDLE is a new request.
REQ-028 Requests arriving outside IDLE (INIT, ISSUE, WAIT, DONE) shall be ignored until IDLE and shall not be lost while held.
REQ-029 Back-to-back: with both requests continuously high, grants shall alternate W, R, W, R, with one IDLE cycle between DONE and the next ISSUE.

Reset
REQ-030 When RESET is high at a clock edge, the block shall enter INIT with all of the following:
- CMD_OUT=0, wr_ack=0, rd_ack=0, busy=1.
- A_out=0, D_out=0, rd_data=0.
- Counter=0, last_grant=read (the first contended grant goes to write).
REQ-031 Reset during ISSUE, WAIT, or DONE shall abort without an ack; the INIT lockout covers any physical cycle still in flight in the NOR interface.

Structure
REQ-032 Shared package flash_pkg shall hold:
- CMD_NOP=0, CMD_READ=1, CMD_WRITE=2.
- The FSM state encoding.
- Default WR_CYCLES, RD_CYCLES, SETTLE_CYCLES.
- Address width 22 and data width 16.
REQ-033 Round-robin selection shall be a sub-module flash_rr_arb2 (inputs req[1:0], last_grant; output grant one-hot); the FSM and counter remain in the top module.

Verification
REQ-034 Defaults: after RESET release, wr_req=1, addr=0x00ABCD, data=0x1234, asserted at cycle 40.
- Required response: CMD_OUT=2 for exactly one cycle, with A_out=0x00ABCD and D_out=0x1234 stable.
- wr_ack pulses exactly 18 cycles after the sampling IDLE cycle.
REQ-035 Read of 0x000010 with D_read model driving 0xBEEF → CMD_OUT=1 for one cycle, then rd_ack 26 cycles after sampling, with rd_data=0xBEEF held afterwards.
REQ-036 wr_req and rd_req both high from the first IDLE → grant order W, R, W, R; no CMD_OUT overlap; each ack is a single-cycle pulse.
REQ-037 Requests asserted at cycle 5 after reset release → no CMD_OUT until cycle 32; then serviced with the REQ-026 latencies.
REQ-038 RESET pulsed during a read's WAIT cycle 10 → no rd_ack; CMD_OUT=0 and busy=1 for SETTLE_CYCLES; the held rd_req is serviced afterwards.

Source files
------------

// File: rtl/flash_pkg.sv
// flash_pkg: shared command codes, FSM encoding, widths and timing defaults for the flash arbiter
package flash_pkg;
  localparam int ADDR_W            = 22;
  localparam int DATA_W            = 16;
  localparam int CNT_W             = 6;
  localparam int DEF_WR_CYCLES     = 16;
  localparam int DEF_RD_CYCLES     = 24;
  localparam int DEF_SETTLE_CYCLES = 32;
  localparam logic GRANT_WR = 1'b0;
  localparam logic GRANT_RD = 1'b1;
  typedef enum logic [1:0] {
    CMD_NOP   = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2
  } cmd_t;
  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;
endpackage

// File: rtl/flash_rr_arb2.sv
// flash_rr_arb2: two-way round-robin grant; bit 0 is the writer, bit 1 the reader
module flash_rr_arb2
  import flash_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);
  always_comb grant = &req ? (last_grant == GRANT_RD ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/flash_access_arbiter.sv
// flash_access_arbiter: shares one NOR flash interface between a writer and a reader
module flash_access_arbiter
  import flash_pkg::*;
#(
  parameter int WR_CYCLES     = DEF_WR_CYCLES,
  parameter int RD_CYCLES     = DEF_RD_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        CMD_OUT,
  output logic [ADDR_W-1:0] A_out,
  output logic [DATA_W-1:0] D_out,
  input  logic [DATA_W-1:0] D_read,
  output logic              busy
);
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last;
  logic              r_rd;
  logic              r_busy;
  logic              r_wr_ack;
  logic              r_rd_ack;
  logic [1:0]        r_cmd;
  logic [ADDR_W-1:0] r_a;
  logic [DATA_W-1:0] r_d;
  logic [DATA_W-1:0] r_rd_data;
  logic [1:0]        w_grant;
  flash_rr_arb2 u_arb (
    .req       ({rd_req, wr_req}),
    .last_grant(r_last),
    .grant     (w_grant)
  );
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= ST_INIT;
      r_cnt     <= '0;
      r_last    <= GRANT_RD;
      r_rd      <= 1'b0;
      r_busy    <= 1'b1;
      r_wr_ack  <= 1'b0;
      r_rd_ack  <= 1'b0;
      r_cmd     <= CMD_NOP;
      r_a       <= '0;
      r_d       <= '0;
      r_rd_data <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (|w_grant) begin
            r_state <= ST_ISSUE;
            r_busy  <= 1'b1;
            r_rd    <= w_grant[1];
            r_last  <= w_grant[1];
            r_cmd   <= w_grant[1] ? CMD_READ : CMD_WRITE;
            r_a     <= w_grant[1] ? rd_addr : wr_addr;
            if (w_grant[0]) r_d <= wr_data;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
          r_cmd   <= CMD_NOP;
          r_cnt   <= r_rd ? CNT_W'(RD_CYCLES - 1) : CNT_W'(WR_CYCLES - 1);
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state  <= ST_DONE;
            r_wr_ack <= ~r_rd;
            r_rd_ack <= r_rd;
            if (r_rd) r_rd_data <= D_read;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          r_state  <= ST_IDLE;
          r_busy   <= 1'b0;
          r_wr_ack <= 1'b0;
          r_rd_ack <= 1'b0;
        end
        default: begin
          r_state <= ST_INIT;
          r_busy  <= 1'b1;
          r_cnt   <= '0;
        end
      endcase
    end
  end
  assign wr_ack  = r_wr_ack;
  assign rd_ack  = r_rd_ack;
  assign rd_data = r_rd_data;
  assign CMD_OUT = r_cmd;
  assign A_out   = r_a;
  assign D_out   = r_d;
  assign busy    = r_busy;
endmodule

// File: tb/tb_flash_access_arbiter.sv
// tb_flash_access_arbiter: scenario tasks plus a scoreboard monitor checking issue/ack traffic
module tb_flash_access_arbiter;
  localparam int WR = 16;
  localparam int RD = 24;
  typedef struct {
    logic        rd;
    logic [21:0] addr;
    logic [15:0] data;
  } txn_t;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        wr_req = 1'b0;
  logic [21:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        rd_req = 1'b0;
  logic [21:0] rd_addr = '0;
  logic        wr_ack, rd_ack, busy;
  logic [15:0] rd_data, D_out, D_read;
  logic [1:0]  CMD_OUT;
  logic [21:0] A_out;
  txn_t exp_q[$];
  int   n_chk = 0, n_fail = 0, m_chk = 0, m_fail = 0;
  int   abort_cnt = 0;

  function automatic logic [15:0] nor_model(input logic [21:0] a);
    return (a == 22'h000010) ? 16'hBEEF : (a[15:0] ^ 16'h5A5A);
  endfunction

  assign D_read = nor_model(A_out);

  flash_access_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .CMD_OUT(CMD_OUT), .A_out(A_out), .D_out(D_out), .D_read(D_read), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Scoreboard consumer: one expected txn per issue, latency and data checked at the ack
  txn_t cur;
  logic active = 1'b0, stable_ok = 1'b1, prev_ack = 1'b0;
  int   m_ptr = 0, mcyc = 0, issue_cyc = 0, abort_seen = 0;
  always @(negedge CLK) begin
    mcyc++;
    if (abort_cnt != abort_seen) begin
      abort_seen = abort_cnt;
      active = 1'b0;
    end
    if (prev_ack) begin
      m_chk++;
      if ((wr_ack | rd_ack) !== 1'b0) begin m_fail++; $display("FAIL sb_ack_pulse: ack high two cycles wr=%b rd=%b", wr_ack, rd_ack); end
    end
    prev_ack = (wr_ack === 1'b1) || (rd_ack === 1'b1);
    if (CMD_OUT === 2'd1 || CMD_OUT === 2'd2 || CMD_OUT === 2'd3) begin
      m_chk++;
      if (active || m_ptr >= exp_q.size()) begin
        m_fail++;
        $display("FAIL sb_issue: CMD_OUT=%0d active=%b pending=%0d, required idle bus and a pending txn", CMD_OUT, active, exp_q.size() - m_ptr);
      end else begin
        cur = exp_q[m_ptr];
        m_ptr++;
        m_chk++;
        if (CMD_OUT !== (cur.rd ? 2'd1 : 2'd2) || A_out !== cur.addr || (!cur.rd && D_out !== cur.data)) begin
          m_fail++;
          $display("FAIL sb_cmd: cmd=%0d A=%h D=%h, required cmd=%0d A=%h D=%h", CMD_OUT, A_out, D_out, cur.rd ? 1 : 2, cur.addr, cur.data);
        end
        active = 1'b1;
        issue_cyc = mcyc;
        stable_ok = 1'b1;
      end
    end else if (active && !prev_ack) begin
      stable_ok &= (A_out === cur.addr) && (cur.rd || D_out === cur.data);
    end
    if (prev_ack) begin
      m_chk++;
      if (!active || rd_ack !== cur.rd || wr_ack !== !cur.rd || mcyc != issue_cyc + 1 + (cur.rd ? RD : WR) ||
          !stable_ok || A_out !== cur.addr || (cur.rd && rd_data !== cur.data)) begin
        m_fail++;
        $display("FAIL sb_ack: wr=%b rd=%b lat=%0d stable=%b rd_data=%h, required rd=%b lat=%0d rd_data=%h",
                 wr_ack, rd_ack, mcyc - issue_cyc, stable_ok, rd_data, cur.rd, 1 + (cur.rd ? RD : WR), cur.data);
      end
      active = 1'b0;
    end
  end

  task automatic start();
    RESET = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_write();
    int k;
    start();
    repeat (40) @(negedge CLK);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_idle: busy=%b expected 0", busy); end
    wr_addr = 22'h00ABCD; wr_data = 16'h1234; wr_req = 1'b1;
    exp_q.push_back('{1'b0, 22'h00ABCD, 16'h1234});
    @(negedge CLK);
    n_chk++; if (CMD_OUT !== 2'd2) begin n_fail++; $display("FAIL write_issue: CMD_OUT=%0d expected 2", CMD_OUT); end
    wr_addr = 22'h3FFFFF; wr_data = 16'hDEAD;
    @(negedge CLK);
    n_chk++; if (CMD_OUT !== 2'd0) begin n_fail++; $display("FAIL write_cmd_once: CMD_OUT=%0d expected 0", CMD_OUT); end
    n_chk++; if (A_out !== 22'h00ABCD || D_out !== 16'h1234) begin n_fail++; $display("FAIL write_hold: A=%h D=%h expected 00abcd 1234", A_out, D_out); end
    k = 2;
    while (wr_ack !== 1'b1 && k < 60) begin @(negedge CLK); k++; end
    n_chk++; if (k != 18) begin n_fail++; $display("FAIL write_ack_latency: %0d expected 18", k); end
    wr_req = 1'b0;
    @(negedge CLK);
    n_chk++; if (wr_ack !== 1'b0) begin n_fail++; $display("FAIL write_ack_pulse: wr_ack=%b expected 0", wr_ack); end
  endtask

  task automatic test_read();
    int k;
    repeat (2) @(negedge CLK);
    rd_addr = 22'h000010; rd_req = 1'b1;
    exp_q.push_back('{1'b1, 22'h000010, 16'hBEEF});
    @(negedge CLK);
    n_chk++; if (CMD_OUT !== 2'd1) begin n_fail++; $display("FAIL read_issue: CMD_OUT=%0d expected 1", CMD_OUT); end
    rd_addr = 22'h2AAAAA;
    @(negedge CLK);
    n_chk++; if (CMD_OUT !== 2'd0) begin n_fail++; $display("FAIL read_cmd_once: CMD_OUT=%0d expected 0", CMD_OUT); end
    k = 2;
    while (rd_ack !== 1'b1 && k < 60) begin @(negedge CLK); k++; end
    n_chk++; if (k != 26) begin n_fail++; $display("FAIL read_ack_latency: %0d expected 26", k); end
    n_chk++; if (rd_data !== 16'hBEEF) begin n_fail++; $display("FAIL read_data: %h expected beef", rd_data); end
    rd_req = 1'b0;
    repeat (5) @(negedge CLK);
    n_chk++; if (rd_data !== 16'hBEEF || rd_ack !== 1'b0) begin n_fail++; $display("FAIL read_hold: rd_data=%h rd_ack=%b expected beef 0", rd_data, rd_ack); end
  endtask

  task automatic test_single_write();
    int k;
    wr_addr = 22'h000222; wr_data = 16'h0F0F; wr_req = 1'b1;
    exp_q.push_back('{1'b0, 22'h000222, 16'h0F0F});
    @(negedge CLK);
    n_chk++; if (CMD_OUT !== 2'd2) begin n_fail++; $display("FAIL single_write_issue: CMD_OUT=%0d expected 2", CMD_OUT); end
    k = 1;
    while (wr_ack !== 1'b1 && k < 60) begin @(negedge CLK); k++; end
    n_chk++; if (k != 18) begin n_fail++; $display("FAIL single_write_latency: %0d expected 18", k); end
    wr_req = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    @(negedge CLK);
    n_chk++; if (CMD_OUT !== 2'd0) begin n_fail++; $display("FAIL reset_cmd: %0d expected 0", CMD_OUT); end
    n_chk++; if (wr_ack !== 1'b0 || rd_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: wr=%b rd=%b expected 0 0", wr_ack, rd_ack); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: %b expected 1", busy); end
    n_chk++; if (A_out !== 22'h0) begin n_fail++; $display("FAIL reset_a_out: %h expected 0", A_out); end
    n_chk++; if (D_out !== 16'h0) begin n_fail++; $display("FAIL reset_d_out: %h expected 0", D_out); end
    n_chk++; if (rd_data !== 16'h0) begin n_fail++; $display("FAIL reset_rd_data: %h expected 0", rd_data); end
  endtask

  task automatic test_early_req();
    int k;
    logic ok;
    start();
    repeat (5) @(negedge CLK);
    wr_addr = 22'h000155; wr_data = 16'h7E57; rd_addr = 22'h0002AA;
    wr_req = 1'b1; rd_req = 1'b1;
    exp_q.push_back('{1'b0, 22'h000155, 16'h7E57});
    exp_q.push_back('{1'b1, 22'h0002AA, nor_model(22'h0002AA)});
    ok = 1'b1;
    for (int i = 6; i < 32; i++) begin
      @(negedge CLK);
      ok &= (CMD_OUT === 2'd0) && (busy === 1'b1);
    end
    n_chk++; if (!ok) begin n_fail++; $display("FAIL early_lockout: CMD_OUT or busy changed during settle, expected 0/1"); end
    @(negedge CLK);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL early_idle: busy=%b expected 0 at cycle 32", busy); end
    @(negedge CLK);
    n_chk++; if (CMD_OUT !== 2'd2) begin n_fail++; $display("FAIL early_first_write: CMD_OUT=%0d expected 2", CMD_OUT); end
    k = 33;
    while (wr_ack !== 1'b1 && k < 120) begin @(negedge CLK); k++; end
    n_chk++; if (k != 50) begin n_fail++; $display("FAIL early_write_ack: cycle %0d expected 50", k); end
    wr_req = 1'b0;
    repeat (2) @(negedge CLK);
    n_chk++; if (CMD_OUT !== 2'd1) begin n_fail++; $display("FAIL early_then_read: CMD_OUT=%0d expected 1", CMD_OUT); end
    k = 52;
    while (rd_ack !== 1'b1 && k < 150) begin @(negedge CLK); k++; end
    n_chk++; if (k != 77) begin n_fail++; $display("FAIL early_read_ack: cycle %0d expected 77", k); end
    rd_req = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    int k, n_ack, n_iss, last_ack;
    logic [3:0] order;
    logic gap_ok;
    start();
    repeat (31) @(negedge CLK);
    wr_addr = 22'h00AAAA; wr_data = 16'h5555; rd_addr = 22'h015555;
    wr_req = 1'b1; rd_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{1'b0, 22'h00AAAA, 16'h5555});
      exp_q.push_back('{1'b1, 22'h015555, nor_model(22'h015555)});
    end
    k = 31; n_ack = 0; n_iss = 0; last_ack = -1; order = 4'b0000; gap_ok = 1'b1;
    while (n_ack < 4 && k < 300) begin
      @(negedge CLK);
      k++;
      if (CMD_OUT !== 2'd0) begin
        if (n_iss < 4) order[n_iss] = (CMD_OUT === 2'd1);
        n_iss++;
        if (last_ack >= 0 && k - last_ack != 2) gap_ok = 1'b0;
      end
      if (wr_ack === 1'b1 || rd_ack === 1'b1) begin n_ack++; last_ack = k; end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    n_chk++; if (n_ack != 4 || n_iss != 4) begin n_fail++; $display("FAIL b2b_count: acks=%0d issues=%0d expected 4 4", n_ack, n_iss); end
    n_chk++; if (order !== 4'b1010) begin n_fail++; $display("FAIL b2b_order: %b expected 1010 (W,R,W,R from bit 0)", order); end
    n_chk++; if (!gap_ok) begin n_fail++; $display("FAIL b2b_gap: ack-to-issue gap not 2 cycles"); end
    repeat (3) @(negedge CLK);
    n_chk++; if (busy !== 1'b0 || CMD_OUT !== 2'd0) begin n_fail++; $display("FAIL b2b_release: busy=%b CMD_OUT=%0d expected 0 0", busy, CMD_OUT); end
  endtask

  task automatic test_reset_abort();
    int k;
    logic ok;
    start();
    repeat (32) @(negedge CLK);
    rd_addr = 22'h000033; rd_req = 1'b1;
    exp_q.push_back('{1'b1, 22'h000033, nor_model(22'h000033)});
    repeat (11) @(negedge CLK);
    n_chk++; if (busy !== 1'b1 || CMD_OUT !== 2'd0 || rd_ack !== 1'b0) begin n_fail++; $display("FAIL abort_in_wait: busy=%b CMD_OUT=%0d rd_ack=%b expected 1 0 0", busy, CMD_OUT, rd_ack); end
    abort_cnt++;
    exp_q.push_back('{1'b1, 22'h000033, nor_model(22'h000033)});
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    ok = 1'b1;
    for (int i = 1; i < 32; i++) begin
      @(negedge CLK);
      ok &= (CMD_OUT === 2'd0) && (busy === 1'b1) && (rd_ack === 1'b0);
    end
    n_chk++; if (!ok) begin n_fail++; $display("FAIL abort_lockout: activity or ack during settle after abort"); end
    @(negedge CLK);
    @(negedge CLK);
    n_chk++; if (CMD_OUT !== 2'd1) begin n_fail++; $display("FAIL abort_reissue: CMD_OUT=%0d expected 1", CMD_OUT); end
    k = 33;
    while (rd_ack !== 1'b1 && k < 120) begin @(negedge CLK); k++; end
    n_chk++; if (k != 58) begin n_fail++; $display("FAIL abort_read_ack: cycle %0d expected 58", k); end
    n_chk++; if (rd_data !== nor_model(22'h000033)) begin n_fail++; $display("FAIL abort_read_data: %h expected %h", rd_data, nor_model(22'h000033)); end
    rd_req = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    test_write();
    test_read();
    test_single_write();
    test_reset();
    test_early_req();
    test_back_to_back();
    test_reset_abort();
    n_chk++; if (m_ptr != exp_q.size()) begin n_fail++; $display("FAIL sb_drain: consumed %0d expected %0d", m_ptr, exp_q.size()); end
    $display("%0d/%0d checks passed", (n_chk + m_chk) - (n_fail + m_fail), n_chk + m_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end
endmodule
